// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings for the fetch/load-store memory port arbiter.
// Owner bits, arbiter states, default depths and the per-request field bundle.
package mem_req_arbiter_pkg;

  localparam logic ARB_SRC_INST = 1'b0;
  localparam logic ARB_SRC_DATA = 1'b1;

  localparam int ARB_MAX_OUTST    = 2;
  localparam int ARB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LOCK_INST = 2'd1,
    ARB_LOCK_DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic arb_state_t lock_state(input logic src);
    return (src == ARB_SRC_DATA) ? ARB_LOCK_DATA : ARB_LOCK_INST;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order 1-bit owner FIFO; zero-latency head, same-cycle push+pop supported.
// No internal backpressure: the caller must not push when full or pop when empty.
module arb_id_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = ARB_MAX_OUTST
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_dat,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] slots;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_dat;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = slots[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates fetch and load/store onto one sram-like port; 0-cycle address and return path.
// Holds grant until mem_addr_ok, stalls both at MAX_OUTST outstanding; ARB_STARVE_GUARD_EN adds fetch anti-starvation.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = ARB_MAX_OUTST
`ifdef ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
`endif
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        arb_err
);

  arb_state_t state;
  arb_state_t state_nxt;

  mem_req_t inst_fields;
  mem_req_t data_fields;
  mem_req_t sel_fields;

  logic sel_src;
  logic src_pend;
  logic force_inst;
  logic accept;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;

  assign inst_fields = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                         addr: inst_addr, wdata: inst_wdata};
  assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                         addr: data_addr, wdata: data_wdata};

  // Source selection: a lock pins the grant, otherwise data wins unless fetch is forced.
  always_comb begin
    sel_src  = ARB_SRC_DATA;
    src_pend = 1'b0;
    case (state)
      ARB_LOCK_INST: begin
        sel_src  = ARB_SRC_INST;
        src_pend = inst_req;
      end
      ARB_LOCK_DATA: begin
        sel_src  = ARB_SRC_DATA;
        src_pend = data_req;
      end
      default: begin
        if (data_req && !force_inst) begin
          sel_src  = ARB_SRC_DATA;
          src_pend = 1'b1;
        end else if (inst_req) begin
          sel_src  = ARB_SRC_INST;
          src_pend = 1'b1;
        end
      end
    endcase
  end

  assign sel_fields = (sel_src == ARB_SRC_DATA) ? data_fields : inst_fields;
  assign mem_req    = resetn & src_pend & ~fifo_full;
  assign accept     = mem_req & mem_addr_ok;
  assign pop        = mem_data_ok & ~fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A lock whose requester has withdrawn is released; mem_req is already low then.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_nxt = lock_state(sel_src);
        end
      end
      default: begin
        if (accept || !src_pend) begin
          state_nxt = ARB_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    mem_wr       = sel_fields.wr;
    mem_size     = sel_fields.size;
    mem_wstrb    = sel_fields.wstrb;
    mem_addr     = sel_fields.addr;
    mem_wdata    = sel_fields.wdata;
    inst_addr_ok = accept & (sel_src == ARB_SRC_INST);
    data_addr_ok = accept & (sel_src == ARB_SRC_DATA);
    inst_data_ok = pop & (fifo_head == ARB_SRC_INST);
    data_data_ok = pop & (fifo_head == ARB_SRC_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_dat (sel_src),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arb_err <= 1'b0;
    end else if (mem_data_ok && fifo_empty) begin
      arb_err <= 1'b1;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;

  // Counts data grants taken while fetch was waiting; saturates at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (sel_src == ARB_SRC_INST || !inst_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign force_inst = inst_req & (starve_cnt == SW'(STARVE_LIMIT));
`else
  assign force_inst = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with an expectation queue checked by a negedge monitor.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        arb_err;

  mem_req_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic src; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  typedef struct { logic src; logic [31:0] rdata; } ret_t;

  acc_t acc_q[$];
  ret_t ret_q[$];
  acc_t mon_a;
  ret_t mon_r;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_acc(input logic src, input logic [31:0] addr);
    acc_t a;
    a.src   = src;
    a.addr  = addr;
    a.wdata = (src == ARB_SRC_DATA) ? ~addr : (addr ^ 32'h0F0F_0F0F);
    acc_q.push_back(a);
  endtask

  task automatic expect_ret(input logic src, input logic [31:0] rdata);
    ret_t r;
    r.src   = src;
    r.rdata = rdata;
    ret_q.push_back(r);
  endtask

  task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                     input logic aok, input logic dok, input logic [31:0] rd);
    inst_req    = ir;
    inst_addr   = ia;
    inst_wdata  = ia ^ 32'h0F0F_0F0F;
    data_req    = dr;
    data_addr   = da;
    data_wdata  = ~da;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: every handshake the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (inst_addr_ok || data_addr_ok) begin
      chk1("acc_onehot", inst_addr_ok & data_addr_ok, 1'b0);
      if (acc_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL acc_unexpected: addr_ok inst=%b data=%b with none expected at %0t",
                 inst_addr_ok, data_addr_ok, $time);
      end else begin
        mon_a = acc_q.pop_front();
        chk1("acc_src", data_addr_ok, mon_a.src);
        chk32("acc_addr", mem_addr, mon_a.addr);
        chk32("acc_wdata", mem_wdata, mon_a.wdata);
      end
    end
    if (inst_data_ok || data_data_ok) begin
      chk1("ret_onehot", inst_data_ok & data_data_ok, 1'b0);
      if (ret_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ret_unexpected: data_ok inst=%b data=%b with none expected at %0t",
                 inst_data_ok, data_data_ok, $time);
      end else begin
        mon_r = ret_q.pop_front();
        chk1("ret_src", data_data_ok, mon_r.src);
        chk32("ret_rdata", data_data_ok ? data_rdata : inst_rdata, mon_r.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  logic exp_src;

  initial begin
    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0;
    data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    resetn = 1'b0;
    drv(1'b1, 32'h1C00_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 32'h0);
    #3;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk1("rst_data_addr_ok", data_addr_ok, 1'b0);
    chk1("rst_data_ok", inst_data_ok | data_data_ok, 1'b0);
    chk1("rst_arb_err", arb_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();

    // Both request together: data first, fetch next cycle, returns in order.
    cyc(); drv(1'b1, 32'h1C00_0100, 1'b1, 32'h8000_0040, 1'b1, 1'b0, 32'h0);
    expect_acc(ARB_SRC_DATA, 32'h8000_0040); expect_ret(ARB_SRC_DATA, 32'hAAAA_0000);
    #3; chk1("a_inst_aok_c0", inst_addr_ok, 1'b0); chk1("a_data_aok_c0", data_addr_ok, 1'b1);
    cyc(); drv(1'b1, 32'h1C00_0100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_acc(ARB_SRC_INST, 32'h1C00_0100); expect_ret(ARB_SRC_INST, 32'h1111_FFFF);
    #3; chk1("a_inst_aok_c1", inst_addr_ok, 1'b1);
    cyc(); idle();
    cyc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0000);
    cyc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_FFFF);
    cyc(); idle();

    // Fetch lock survives a late data request.
    cyc(); drv(1'b1, 32'h1C00_0000, 1'b0, 32'h8000_1000, 1'b0, 1'b0, 32'h0);
    #3; chk1("b_req_c0", mem_req, 1'b1); chk32("b_addr_c0", mem_addr, 32'h1C00_0000);
    for (int k = 1; k < 3; k++) begin
      cyc(); drv(1'b1, 32'h1C00_0000, 1'b1, 32'h8000_1000, 1'b0, 1'b0, 32'h0);
      #3; chk32("b_addr_locked", mem_addr, 32'h1C00_0000);
    end
    cyc(); drv(1'b1, 32'h1C00_0000, 1'b1, 32'h8000_1000, 1'b1, 1'b0, 32'h0);
    expect_acc(ARB_SRC_INST, 32'h1C00_0000); expect_ret(ARB_SRC_INST, 32'h2222_0001);
    cyc(); drv(1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b1, 1'b0, 32'h0);
    expect_acc(ARB_SRC_DATA, 32'h8000_1000); expect_ret(ARB_SRC_DATA, 32'h2222_0002);
    #3; chk32("b_addr_data", mem_addr, 32'h8000_1000);
    cyc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_0001);
    cyc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_0002);
    cyc(); idle();

    // Full stall: a same-cycle pop does not unblock, acceptance resumes next cycle.
    cyc(); drv(1'b0, 32'h0, 1'b1, 32'h8000_2000, 1'b1, 1'b0, 32'h0);
    expect_acc(ARB_SRC_DATA, 32'h8000_2000); expect_ret(ARB_SRC_DATA, 32'h3333_0000);
    cyc(); drv(1'b0, 32'h0, 1'b1, 32'h8000_2004, 1'b1, 1'b0, 32'h0);
    expect_acc(ARB_SRC_DATA, 32'h8000_2004); expect_ret(ARB_SRC_DATA, 32'h3333_0004);
    cyc(); drv(1'b0, 32'h0, 1'b1, 32'h8000_2008, 1'b1, 1'b0, 32'h0);
    #3; chk1("c_full_mem_req", mem_req, 1'b0); chk1("c_full_aok", data_addr_ok, 1'b0);
    cyc(); drv(1'b0, 32'h0, 1'b1, 32'h8000_2008, 1'b1, 1'b1, 32'h3333_0000);
    #3; chk1("c_pop_same_cycle", mem_req, 1'b0);
    cyc(); drv(1'b0, 32'h0, 1'b1, 32'h8000_2008, 1'b1, 1'b0, 32'h0);
    expect_acc(ARB_SRC_DATA, 32'h8000_2008); expect_ret(ARB_SRC_DATA, 32'h3333_0008);
    #3; chk1("c_resume", mem_req, 1'b1);
    cyc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3333_0004);
    cyc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3333_0008);
    cyc(); idle();

    // Push and pop together at count 1 keep count at 1.
    cyc(); drv(1'b1, 32'h1C00_0300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_acc(ARB_SRC_INST, 32'h1C00_0300); expect_ret(ARB_SRC_INST, 32'h4444_0000);
    cyc(); drv(1'b0, 32'h0, 1'b1, 32'h8000_3000, 1'b1, 1'b1, 32'h4444_0000);
    expect_acc(ARB_SRC_DATA, 32'h8000_3000); expect_ret(ARB_SRC_DATA, 32'h4444_0001);
    cyc(); drv(1'b1, 32'h1C00_0304, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_acc(ARB_SRC_INST, 32'h1C00_0304); expect_ret(ARB_SRC_INST, 32'h4444_0002);
    #3; chk1("d_count_one", mem_req, 1'b1);
    cyc(); drv(1'b1, 32'h1C00_0308, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #3; chk1("d_count_full", mem_req, 1'b0);
    cyc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_0001);
    cyc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4444_0002);
    cyc(); idle();

    // Continuous contention with immediate returns.
    for (int k = 0; k < 10; k++) begin
      cyc();
`ifdef ARB_STARVE_GUARD_EN
      exp_src = (k % 5 == 4) ? ARB_SRC_INST : ARB_SRC_DATA;
`else
      exp_src = ARB_SRC_DATA;
`endif
      drv(1'b1, 32'h1C00_0200, 1'b1, 32'h8000_0200, 1'b1, (k > 0), 32'h5000_0000 + k - 1);
      expect_acc(exp_src, (exp_src == ARB_SRC_DATA) ? 32'h8000_0200 : 32'h1C00_0200);
      expect_ret(exp_src, 32'h5000_0000 + k);
    end
    cyc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5000_0009);
    cyc(); idle();

    // Return with nothing outstanding.
    cyc(); #3; chk1("e_err_before", arb_err, 1'b0);
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    cyc(); idle();
    #3; chk1("e_err_set", arb_err, 1'b1);
    repeat (3) cyc();
    #3; chk1("e_err_held", arb_err, 1'b1);

    // Reset while locked with one outstanding.
    cyc(); drv(1'b1, 32'h1C00_0400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_acc(ARB_SRC_INST, 32'h1C00_0400);
    cyc(); drv(1'b0, 32'h0, 1'b1, 32'h8000_4000, 1'b0, 1'b0, 32'h0);
    #3; chk1("g_lock_req", mem_req, 1'b1);
    cyc(); drv(1'b1, 32'h1C00_0404, 1'b1, 32'h8000_4000, 1'b1, 1'b1, 32'h7777_0000);
    resetn = 1'b0;
    #1;
    chk1("g_rst_mem_req", mem_req, 1'b0);
    chk1("g_rst_inst_aok", inst_addr_ok, 1'b0);
    chk1("g_rst_data_aok", data_addr_ok, 1'b0);
    chk1("g_rst_data_ok", inst_data_ok | data_data_ok, 1'b0);
    chk1("g_rst_err", arb_err, 1'b0);
    cyc(); resetn = 1'b1;
    drv(1'b1, 32'h1C00_0404, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3; chk1("g_idle_req", mem_req, 1'b1); chk32("g_idle_addr", mem_addr, 32'h1C00_0404);
    cyc(); drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_0001);
    #3; chk1("g_err_before", arb_err, 1'b0);
    cyc(); idle();
    #3; chk1("g_stale_err", arb_err, 1'b1);

    cyc();
    chk32("acc_q_drained", acc_q.size(), 32'd0);
    chk32("ret_q_drained", ret_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
